toast_wb_arbiter: RTL

- Shares the single register-file write port (rd_addr / rd_wr_data / rd_wr_en) between two writers: the in-order pipeline writeback and a long-latency external unit (MAC/divider accelerator) using a valid/ready handshake.
- Pipeline writes have priority. External results are buffered in a small FIFO. A starvation counter forces a pipeline stall so the external unit cannot be locked out.
- Provides a pending-destination scoreboard so ID can stall on sources whose results are still queued.

---
 rtl/toast_wb_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/toast_wb_arbiter.sv
// Arbitrates the single regfile write port between pipeline writeback and a buffered
// external result stream, with a starvation stall and a pending-destination scoreboard.
module toast_wb_arbiter #(
   parameter int unsigned REG_DATA_WIDTH     = 32,
   parameter int unsigned REGFILE_ADDR_WIDTH = 5,
   parameter int unsigned EXT_FIFO_DEPTH     = 2,
   parameter int unsigned STARVE_LIMIT       = 4
) (
   input  logic                          clk_i,
   input  logic                          resetn_i,
   input  logic                          pipe_wr_en_i,
   input  logic [REGFILE_ADDR_WIDTH-1:0] pipe_rd_addr_i,
   input  logic [REG_DATA_WIDTH-1:0]     pipe_wr_data_i,
   input  logic                          ext_valid_i,
   output logic                          ext_ready_o,
   input  logic [REGFILE_ADDR_WIDTH-1:0] ext_rd_addr_i,
   input  logic [REG_DATA_WIDTH-1:0]     ext_data_i,
   output logic                          stall_o,
   output logic [REGFILE_ADDR_WIDTH-1:0] rd_addr_o,
   output logic [REG_DATA_WIDTH-1:0]     rd_wr_data_o,
   output logic                          rd_wr_en_o,
   input  logic [REGFILE_ADDR_WIDTH-1:0] q1_addr_i,
   input  logic [REGFILE_ADDR_WIDTH-1:0] q2_addr_i,
   output logic                          q1_pending_o,
   output logic                          q2_pending_o,
   output logic                          protocol_err_o
);

   localparam int unsigned PtrW  = (EXT_FIFO_DEPTH > 1) ? $clog2(EXT_FIFO_DEPTH) : 1;
   localparam int unsigned CntW  = $clog2(EXT_FIFO_DEPTH + 1);
   localparam int unsigned WaitW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StForce} state_e;

   state_e                        state_q;
   logic [WaitW-1:0]              wait_q;
   logic                          stall_q;
   logic                          perr_q;
   logic [CntW-1:0]               count_q, count_d;
   logic [PtrW-1:0]               rd_ptr_q, wr_ptr_q;
   logic [REGFILE_ADDR_WIDTH-1:0] addr_q [EXT_FIFO_DEPTH];
   logic [REG_DATA_WIDTH-1:0]     data_q [EXT_FIFO_DEPTH];
   logic [EXT_FIFO_DEPTH-1:0]     vld_q;

   logic pipe_use, fifo_ne, pop, push;

   always_comb begin
      pipe_use    = pipe_wr_en_i && (pipe_rd_addr_i != '0);
      fifo_ne     = (count_q != '0);
      pop         = !pipe_use && fifo_ne;
      ext_ready_o = resetn_i && (count_q < CntW'(EXT_FIFO_DEPTH));
      // x0 results are handshaken but never stored
      push        = ext_valid_i && ext_ready_o && (ext_rd_addr_i != '0);
      count_d     = count_q;
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_comb begin
      rd_wr_en_o   = resetn_i && (pipe_use || fifo_ne);
      rd_addr_o    = pipe_use ? pipe_rd_addr_i : addr_q[rd_ptr_q];
      rd_wr_data_o = pipe_use ? pipe_wr_data_i : data_q[rd_ptr_q];
   end

   // The entry popping this cycle stays pending; the regfile forwards it.
   always_comb begin
      q1_pending_o = 1'b0;
      q2_pending_o = 1'b0;
      for (int i = 0; i < EXT_FIFO_DEPTH; i++) begin
         if (vld_q[i] && (q1_addr_i != '0) && (addr_q[i] == q1_addr_i)) q1_pending_o = 1'b1;
         if (vld_q[i] && (q2_addr_i != '0) && (addr_q[i] == q2_addr_i)) q2_pending_o = 1'b1;
      end
   end

   assign stall_o        = stall_q;
   assign protocol_err_o = perr_q;

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q  <= StIdle;
         wait_q   <= '0;
         stall_q  <= 1'b0;
         perr_q   <= 1'b0;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         vld_q    <= '0;
         for (int i = 0; i < EXT_FIFO_DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if (push) begin
            addr_q[wr_ptr_q] <= ext_rd_addr_i;
            data_q[wr_ptr_q] <= ext_data_i;
            vld_q[wr_ptr_q]  <= 1'b1;
            wr_ptr_q         <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            vld_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q        <= rd_ptr_q + PtrW'(1);
         end
         count_q <= count_d;
         if (pipe_use && stall_q) perr_q <= 1'b1;

         unique case (state_q)
            StIdle: begin
               wait_q <= '0;
               if (count_d != '0) state_q <= StWait;
            end
            StWait: begin
               if (pop) begin
                  wait_q <= '0;
                  if (count_d == '0) state_q <= StIdle;
               end else if (wait_q == WaitW'(STARVE_LIMIT - 1)) begin
                  wait_q  <= '0;
                  stall_q <= 1'b1;
                  state_q <= StForce;
               end else begin
                  wait_q <= wait_q + WaitW'(1);
               end
            end
            StForce: begin
               // A pipe write during the stall keeps us here until the head drains.
               if (pop) begin
                  wait_q  <= '0;
                  stall_q <= 1'b0;
                  state_q <= (count_d != '0) ? StWait : StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
